register_bank_v3: RTL

- Parametrised successor to the 32x32 register bank.
- Configurable width and depth, byte-enable writes, optional hardwired-zero entry 0.
- Registered reads with write-to-read forwarding.
- Sequenced bulk-clear engine, so the whole bank can be cleared without asserting reset.
- Sits beside the datapath as the architectural register file; the pipeline control block drives it.

---
 rtl/register_bank_pkg.sv | 36 +++
 rtl/register_bank_clr_fsm.sv | 81 ++++++++
 rtl/register_bank_v3.sv | 126 ++++++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
//   clr_state_t : bulk-clear FSM state encoding
//   byte_merge  : byte-enable merge used by the write and forwarding paths
package register_bank_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Default data width and its byte-enable width.
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned BE_W       = DEF_DATA_W / 8;

    // byte_merge works on the widest supported word; callers widen and
    // truncate so one helper serves every DATA_W up to MAX_DATA_W.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    // New bytes where be is set, old bytes elsewhere.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_v;
        for (int unsigned i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/register_bank_clr_fsm.sv
// Bulk-clear sequencer: walks a pointer over every entry, one per cycle.
//   clk, reset_n  : clock, synchronous active-low reset
//   i_clr_start   : one-cycle clear request (ignored while clearing)
//   i_write       : write strobe, used only to flag dropped writes
//   o_busy        : high for exactly 2**ADDR_W cycles per clear
//   o_wr_err      : pulses the cycle after a write dropped during a clear
//   o_clr_we      : clear-write enable to the storage array
//   o_clr_addr    : entry being cleared this cycle
module register_bank_clr_fsm
    import register_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr_start,
    input  logic              i_write,
    output logic              o_busy,
    output logic              o_wr_err,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_wr_err;
    logic              w_wr_err_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= w_busy_nxt;
            r_wr_err <= w_wr_err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_wr_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_clr_start) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                w_wr_err_nxt = i_write;
                // Pointer wraps to 0 naturally on the last entry.
                w_ptr_nxt    = r_ptr + ADDR_W'(1);
                if (r_ptr == '1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == CLEAR);
    end

    assign o_busy     = r_busy;
    assign o_wr_err   = r_wr_err;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/register_bank_v3.sv
// Architectural register file: 2 registered read ports, 1 byte-enable write
// port with write-to-read forwarding, optional hardwired-zero entry 0 and a
// sequenced bulk clear.
//   clk, reset_n          : clock, synchronous active-low reset
//   sr1, sr2, rd_en       : read addresses and shared read strobe
//   rd_data1, rd_data2    : read data, 1-cycle latency, held when rd_en=0
//   rd_valid              : registered rd_en
//   dr, wr_data, wr_be    : write address, data, byte enables
//   write                 : write strobe
//   clr_start             : start a bulk clear
//   busy, wr_err          : clear in progress, dropped-write pulse
module register_bank_v3
    import register_bank_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     sr1,
    input  logic [ADDR_W-1:0]     sr2,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data1,
    output logic [DATA_W-1:0]     rd_data2,
    output logic                  rd_valid,
    input  logic [ADDR_W-1:0]     dr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  write,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  wr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic              r_rd_valid;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;

    register_bank_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clr_start (clr_start),
        .i_write     (write),
        .o_busy      (w_busy),
        .o_wr_err    (wr_err),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    // Writes are dropped while clearing; writes to entry 0 vanish when it is hardwired.
    assign w_wr_acc = write && !w_busy && !((ZERO_R0 != 0) && (dr == '0));

    assign w_wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(r_mem[dr]),
                                            MAX_DATA_W'(wr_data),
                                            MAX_BE_W'(wr_be)));

    // Read-port next values; later assignments take priority.
    always_comb begin
        w_rd1_nxt = r_mem[sr1];
        if (w_wr_acc && (dr == sr1)) begin
            w_rd1_nxt = w_wr_merged;
        end
        if (w_clr_we && (w_clr_addr == sr1)) begin
            w_rd1_nxt = '0;
        end
        if ((ZERO_R0 != 0) && (sr1 == '0)) begin
            w_rd1_nxt = '0;
        end
    end

    always_comb begin
        w_rd2_nxt = r_mem[sr2];
        if (w_wr_acc && (dr == sr2)) begin
            w_rd2_nxt = w_wr_merged;
        end
        if (w_clr_we && (w_clr_addr == sr2)) begin
            w_rd2_nxt = '0;
        end
        if ((ZERO_R0 != 0) && (sr2 == '0)) begin
            w_rd2_nxt = '0;
        end
    end

    // Storage array and read registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[ADDR_W'(i)] <= '0;
            end
            r_rd_data1 <= '0;
            r_rd_data2 <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr_acc) begin
                r_mem[dr] <= w_wr_merged;
            end
            if (rd_en) begin
                r_rd_data1 <= w_rd1_nxt;
                r_rd_data2 <= w_rd2_nxt;
            end
            r_rd_valid <= rd_en;
        end
    end

    assign rd_data1 = r_rd_data1;
    assign rd_data2 = r_rd_data2;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;

endmodule
